alu_issuer: RTL

Initiator-side sequencer for the `alu` datapath. It accepts operation requests on a valid/ready channel and drives the ALU's OP1/OP2/OPCODE inputs, holding them stable for a fixed latency. It then samples the ALU result and returns it, with a tag, on a second valid/ready channel. It sits between the control/test logic and the `alu` instance, so neither side has to know the ALU latency.

---
 rtl/alu_pkg.sv | 25 ++
 rtl/alu_issuer.sv | 122 ++++++++++++
 2 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the alu datapath and its issuer: default widths,
// opcode encoding and the issuer FSM state type.
package alu_pkg;

  localparam int ALU_DATA_W = 4;
  localparam int ALU_OPC_W  = 3;

  typedef enum logic [ALU_OPC_W-1:0] {
    OPC_ADD  = 3'd0,
    OPC_SUB  = 3'd1,
    OPC_AND  = 3'd2,
    OPC_OR   = 3'd3,
    OPC_XOR  = 3'd4,
    OPC_PASS = 3'd5,
    OPC_SHL  = 3'd6,
    OPC_SHR  = 3'd7
  } alu_opcode_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } issuer_state_t;

endpackage

// File: rtl/alu_issuer.sv
// Single-outstanding request sequencer in front of a fixed-latency ALU:
// drives and holds the ALU operands, samples the result, returns it with a tag.
module alu_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W  = ALU_DATA_W,
  parameter int OPC_W   = ALU_OPC_W,
  parameter int LATENCY = 1,
  parameter int TAG_W   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_op1,
  input  logic [DATA_W-1:0] req_op2,
  input  logic [OPC_W-1:0]  req_opcode,
  input  logic [TAG_W-1:0]  req_tag,
  output logic [DATA_W-1:0] OP1,
  output logic [DATA_W-1:0] OP2,
  output logic [OPC_W-1:0]  OPCODE,
  input  logic [DATA_W:0]   alu_result,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W:0]   rsp_result,
  output logic [TAG_W-1:0]  rsp_tag,
  output logic              busy,
  output logic [7:0]        txn_count
);

  localparam logic [3:0] WAIT_LOAD = 4'(LATENCY);

  issuer_state_t    state, state_nxt;
  logic [3:0]       wait_cnt, wait_cnt_nxt;
  logic             out_of_reset;
  logic             accept, capture, rsp_fire;
  logic [TAG_W-1:0] tag_q;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= ST_IDLE;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_cnt_nxt;
    end
  end

  // NOTE: every signal driven here gets a default first, so no path infers a latch.
  always_comb begin
    state_nxt    = state;
    wait_cnt_nxt = wait_cnt;
    req_ready    = 1'b0;
    accept       = 1'b0;
    capture      = 1'b0;
    rsp_fire     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        req_ready = out_of_reset;
        if (req_valid && out_of_reset) begin
          accept       = 1'b1;
          wait_cnt_nxt = WAIT_LOAD;
          state_nxt    = ST_WAIT;
        end
      end
      ST_WAIT: begin
        wait_cnt_nxt = wait_cnt - 4'd1;
        if (wait_cnt == 4'd1) begin
          capture   = 1'b1;
          state_nxt = ST_RESP;
        end
      end
      ST_RESP: begin
        // A consumer handshake frees the slot, so a waiting request can be taken in the same edge.
        req_ready = rsp_ready;
        if (rsp_ready) begin
          rsp_fire = 1'b1;
          if (req_valid) begin
            accept       = 1'b1;
            wait_cnt_nxt = WAIT_LOAD;
            state_nxt    = ST_WAIT;
          end else begin
            state_nxt = ST_IDLE;
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // NOTE: every datapath register is reset, since all of them are visible at the ports.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_of_reset <= 1'b0;
      OP1          <= '0;
      OP2          <= '0;
      OPCODE       <= '0;
      tag_q        <= '0;
      rsp_result   <= '0;
      rsp_tag      <= '0;
      txn_count    <= 8'd0;
    end else begin
      out_of_reset <= 1'b1;
      if (accept) begin
        OP1    <= req_op1;
        OP2    <= req_op2;
        OPCODE <= req_opcode;
        tag_q  <= req_tag;
      end
      if (capture) begin
        rsp_result <= alu_result;
        rsp_tag    <= tag_q;
      end
      if (rsp_fire) txn_count <= txn_count + 8'd1;
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

endmodule
